// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard controller: load scoreboard, stall/replay accounting and
// redirect flush sequencing for the front end.
module hazard_stall_ctrl #(
  parameter int NREGS     = 16,
  parameter int LOAD_LAT  = 2,
  parameter int MAX_STALL = 2,
  parameter int FLUSH_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_valid,
  input  logic [3:0] dec_ra,
  input  logic [3:0] dec_rb,
  input  logic       dec_ra_used,
  input  logic       dec_rb_used,
  input  logic       dec_is_load,
  input  logic [3:0] dec_rd,
  input  logic       mem_busy,
  input  logic       ex_redirect,
  output logic       stall,
  output logic       flush,
  output logic       issue,
  output logic       replay,
  output logic [1:0] stall_cnt,
  output logic       overflow
);

  localparam logic [1:0] LAT      = 2'(LOAD_LAT);
  localparam logic [1:0] CNT_MAX  = 2'(MAX_STALL);
  localparam logic [1:0] FL_EXTRA = 2'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {RUN, STALL, REPLAY, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              fcnt_q, fcnt_d;
  logic [1:0]              stall_cnt_q, stall_cnt_d;
  logic                    overflow_q, overflow_d;
  logic [NREGS-1:0][1:0]   pend_q, pend_d;

  logic haz_ra, haz_rb, haz;
  logic flush_i, stall_i, issue_i, replay_i, load_set;

  // An entry of 1 marks the load's writeback cycle, where the result is
  // forwarded, so only entries above 1 block a dependent read.
  always_comb begin
    haz_ra = dec_ra_used && (dec_ra != 4'd0) && (pend_q[dec_ra] > 2'd1);
    haz_rb = dec_rb_used && (dec_rb != 4'd0) && (pend_q[dec_rb] > 2'd1);
    haz    = mem_busy || (dec_valid && (haz_ra || haz_rb));
  end

  always_comb begin
    flush_i  = ex_redirect || (state_q == FLUSH);
    stall_i  = haz && !flush_i;
    issue_i  = dec_valid && !stall_i && !flush_i;
    replay_i = (stall_cnt_q != 2'd0) && !stall_i && !flush_i;
    load_set = issue_i && dec_is_load && (dec_rd != 4'd0);
  end

  // Reset only masks the ports; next-state logic works on the ungated terms.
  assign stall     = stall_i  && !reset;
  assign flush     = flush_i  && !reset;
  assign issue     = issue_i  && !reset;
  assign replay    = replay_i && !reset;
  assign stall_cnt = stall_cnt_q;
  assign overflow  = overflow_q;

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      if (i != 0 && load_set && dec_rd == 4'(i)) begin
        pend_d[i] = LAT;
      end else if (pend_q[i] != 2'd0) begin
        pend_d[i] = pend_q[i] - 2'd1;
      end else begin
        pend_d[i] = 2'd0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      stall_cnt_d = 2'd0;
    end else if (stall_i) begin
      if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 2'd1;
    end else if (replay_i) begin
      stall_cnt_d = stall_cnt_q - 2'd1;
    end
    overflow_d = overflow_q || (stall_i && (stall_cnt_q == CNT_MAX) && !flush_i);
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (ex_redirect) begin
      state_d = (FLUSH_CYC > 1) ? FLUSH : RUN;
      fcnt_d  = FL_EXTRA;
    end else begin
      case (state_q)
        RUN:    if (haz) state_d = STALL;
        STALL:  if (!haz) state_d = (stall_cnt_d == 2'd0) ? RUN : REPLAY;
        REPLAY: begin
          if (haz) state_d = STALL;
          else if (stall_cnt_d == 2'd0) state_d = RUN;
        end
        FLUSH: begin
          if (fcnt_q <= 2'd1) begin
            state_d = RUN;
            fcnt_d  = 2'd0;
          end else begin
            fcnt_d = fcnt_q - 2'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      fcnt_q      <= 2'd0;
      stall_cnt_q <= 2'd0;
      overflow_q  <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      overflow_q  <= overflow_d;
      pend_q      <= pend_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: each driven cycle queues its expected outputs, and a
// negedge monitor pops and compares them.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       dec_valid = 1'b0;
  logic [3:0] dec_ra = 4'd0;
  logic [3:0] dec_rb = 4'd0;
  logic       dec_ra_used = 1'b0;
  logic       dec_rb_used = 1'b0;
  logic       dec_is_load = 1'b0;
  logic [3:0] dec_rd = 4'd0;
  logic       mem_busy = 1'b0;
  logic       ex_redirect = 1'b0;
  logic       stall, flush, issue, replay, overflow;
  logic [1:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];
  string      name_q[$];

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_ra(dec_ra), .dec_rb(dec_rb),
    .dec_ra_used(dec_ra_used), .dec_rb_used(dec_rb_used),
    .dec_is_load(dec_is_load), .dec_rd(dec_rd),
    .mem_busy(mem_busy), .ex_redirect(ex_redirect),
    .stall(stall), .flush(flush), .issue(issue), .replay(replay),
    .stall_cnt(stall_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {stall, flush, issue, replay, overflow, stall_cnt}
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [6:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {stall, flush, issue, replay, overflow, stall_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %b required %b", nm, a, e);
      end else begin
        $display("ok   %s: %b", nm, a);
      end
    end
  end

  task automatic step(input logic rst, input logic v,
                      input logic [3:0] ra, input logic rau,
                      input logic [3:0] rb, input logic rbu,
                      input logic ld, input logic [3:0] rd,
                      input logic mb, input logic rx,
                      input logic [6:0] e, input string nm);
    @(posedge clk);
    #1;
    reset = rst; dec_valid = v;
    dec_ra = ra; dec_ra_used = rau;
    dec_rb = rb; dec_rb_used = rbu;
    dec_is_load = ld; dec_rd = rd;
    mem_busy = mb; ex_redirect = rx;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    // reset masks everything, release exposes the mem_busy stall at once
    step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000_0_00, "rst_busy");
    step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000_0_00, "rst_hold");
    step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1000_0_00, "rel_stall");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0001_0_01, "rel_replay");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000_0_00, "idle");
    // load-use on r3
    step(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 7'b0010_0_00, "ld_r3");
    step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 7'b1000_0_00, "use_r3_stall");
    step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 7'b0011_0_01, "use_r3_replay");
    step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 7'b0010_0_00, "use_r3_issue");
    // r0 and unused/used rb
    step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 7'b0010_0_00, "ld_r0");
    step(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 7'b0010_0_00, "use_r0");
    step(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 7'b0010_0_00, "ld_r5");
    step(0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 7'b0010_0_00, "r5_unused");
    step(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 7'b0010_0_00, "ld_r5b");
    step(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 7'b1000_0_00, "use_rb5_stall");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0001_0_01, "rb5_replay");
    // redirect during stall
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1000_0_00, "busy1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0100_0_01, "redirect");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0100_0_00, "flush2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000_0_00, "post_flush");
    // saturation and sticky overflow
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1000_0_00, "sat1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1000_0_01, "sat2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1000_0_10, "sat3");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0001_1_10, "ovf_replay2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0001_1_01, "ovf_replay1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000_1_00, "ovf_sticky");
    // set beats decrement on r4
    step(0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 7'b0010_1_00, "ld_r4");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0010_1_00, "indep");
    step(0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 7'b0010_1_00, "ld_r4_conflict");
    step(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 7'b1000_1_00, "use_r4_stall");
    step(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 7'b0011_1_01, "use_r4_replay");
    step(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 7'b0010_1_00, "use_r4_issue");
    // redirect during flush restarts the count
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7'b0100_1_00, "redir_a");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b0100_1_00, "redir_b");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0100_1_00, "flush_tail");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0010_1_00, "after_flush");
    // reset mid-run masks a redirect and clears overflow
    step(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0000_0_00, "rst_mid");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0010_0_00, "rst_release");
    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
